// File: rtl/fetch_redirect_arb_if.sv
// Redirect request channel between the redirect arbiter (master) and pre-IF (slave).
interface fetch_redirect_arb_if #(
  parameter int PC_W = 32
);
  logic            req_valid;
  logic [PC_W-1:0] req_pc;
  logic [2:0]      req_cause;
  logic            req_ready;

  modport master (
    output req_valid,
    output req_pc,
    output req_cause,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_pc,
    input  req_cause,
    output req_ready
  );
endinterface

// File: rtl/fetch_redirect_arb.sv
// Front-end redirect arbiter: picks the winning flush/mispredict, buffers one pending
// redirect PC, owns the idle sleep state, and issues the boot fetch after reset.
module fetch_redirect_arb #(
  parameter int          PC_W     = 32,
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   excp_flush,
  input  logic [PC_W-1:0]        excp_pc,
  input  logic                   ertn_flush,
  input  logic [PC_W-1:0]        era_pc,
  input  logic                   refetch_flush,
  input  logic                   idle_flush,
  input  logic [PC_W-1:0]        ws_pc,
  input  logic                   br_flush,
  input  logic [PC_W-1:0]        br_target,
  input  logic                   has_int,
  fetch_redirect_arb_if.master   req,
  output logic                   fs_kill,
  output logic                   fetch_hold,
  output logic [CNT_W-1:0]       redir_cnt,
  output logic [CNT_W-1:0]       sleep_cnt
);

  typedef enum logic [1:0] {EMPTY, PEND, SLEEP} state_t;

  localparam logic [2:0] CAUSE_BOOT    = 3'd0;
  localparam logic [2:0] CAUSE_EXCP    = 3'd1;
  localparam logic [2:0] CAUSE_ERTN    = 3'd2;
  localparam logic [2:0] CAUSE_REFETCH = 3'd3;
  localparam logic [2:0] CAUSE_WAKE    = 3'd4;
  localparam logic [2:0] CAUSE_BRANCH  = 3'd5;

  state_t          state, state_nxt;
  logic [PC_W-1:0] buf_pc, buf_pc_nxt;
  logic [2:0]      buf_cause, buf_cause_nxt;
  logic            buf_is_wb, buf_is_wb_nxt;
  logic            wb_flush, br_take, handshake;
  logic [PC_W-1:0] seq_pc;

  // A branch correction is stale if WB flushes now, we sleep, or a WB redirect is already pending.
  always_comb begin
    wb_flush  = excp_flush | ertn_flush | refetch_flush | idle_flush;
    br_take   = br_flush && !wb_flush && (state != SLEEP) && !((state == PEND) && buf_is_wb);
    seq_pc    = ws_pc + PC_W'(4);
    handshake = (state == PEND) && req.req_ready;
  end

  always_comb begin
    state_nxt     = state;
    buf_pc_nxt    = buf_pc;
    buf_cause_nxt = buf_cause;
    buf_is_wb_nxt = buf_is_wb;
    case (state)
      SLEEP: begin
        if (excp_flush) begin
          buf_pc_nxt = excp_pc; buf_cause_nxt = CAUSE_EXCP; buf_is_wb_nxt = 1'b1; state_nxt = PEND;
        end else if (ertn_flush) begin
          buf_pc_nxt = era_pc; buf_cause_nxt = CAUSE_ERTN; buf_is_wb_nxt = 1'b1; state_nxt = PEND;
        end else if (has_int) begin
          buf_cause_nxt = CAUSE_WAKE; state_nxt = PEND;
        end
      end
      default: begin
        if (excp_flush) begin
          buf_pc_nxt = excp_pc; buf_cause_nxt = CAUSE_EXCP; buf_is_wb_nxt = 1'b1; state_nxt = PEND;
        end else if (ertn_flush) begin
          buf_pc_nxt = era_pc; buf_cause_nxt = CAUSE_ERTN; buf_is_wb_nxt = 1'b1; state_nxt = PEND;
        end else if (refetch_flush) begin
          buf_pc_nxt = seq_pc; buf_cause_nxt = CAUSE_REFETCH; buf_is_wb_nxt = 1'b1; state_nxt = PEND;
        end else if (idle_flush) begin
          // A wake interrupt already present skips the sleep entirely.
          buf_pc_nxt    = seq_pc;
          buf_cause_nxt = CAUSE_WAKE;
          buf_is_wb_nxt = 1'b1;
          state_nxt     = has_int ? PEND : SLEEP;
        end else if (br_take) begin
          buf_pc_nxt = br_target; buf_cause_nxt = CAUSE_BRANCH; buf_is_wb_nxt = 1'b0; state_nxt = PEND;
        end else if (handshake) begin
          state_nxt = EMPTY;
        end
      end
    endcase
  end

  // Boot request counts as WB-originated: no older branch can be in flight before the first fetch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= PEND;
      buf_pc    <= PC_W'(RESET_PC);
      buf_cause <= CAUSE_BOOT;
      buf_is_wb <= 1'b1;
      redir_cnt <= '0;
      sleep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      buf_pc    <= buf_pc_nxt;
      buf_cause <= buf_cause_nxt;
      buf_is_wb <= buf_is_wb_nxt;
      if (handshake) redir_cnt <= redir_cnt + CNT_W'(1);
      if (state == SLEEP) sleep_cnt <= sleep_cnt + CNT_W'(1);
    end
  end

  assign req.req_valid = (state == PEND);
  assign req.req_pc    = buf_pc;
  assign req.req_cause = buf_cause;
  assign fetch_hold    = (state != EMPTY);
  assign fs_kill       = wb_flush | br_take;

endmodule

// File: tb/tb_fetch_redirect_arb.sv
// Directed self-checking bench for fetch_redirect_arb: a vector table for the
// single-cycle scenarios plus hand sequences for sleep/wake and reset.
module tb_fetch_redirect_arb;
  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        excp_flush, ertn_flush, refetch_flush, idle_flush, br_flush, has_int;
  logic [31:0] excp_pc, era_pc, ws_pc, br_target;
  logic        fs_kill, fetch_hold;
  logic [31:0] redir_cnt, sleep_cnt;
  int          checks = 0;
  int          errors = 0;

  fetch_redirect_arb_if #(.PC_W(32)) req_if ();

  fetch_redirect_arb #(.PC_W(32), .RESET_PC(RESET_PC), .CNT_W(32)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .excp_flush    (excp_flush),
    .excp_pc       (excp_pc),
    .ertn_flush    (ertn_flush),
    .era_pc        (era_pc),
    .refetch_flush (refetch_flush),
    .idle_flush    (idle_flush),
    .ws_pc         (ws_pc),
    .br_flush      (br_flush),
    .br_target     (br_target),
    .has_int       (has_int),
    .req           (req_if),
    .fs_kill       (fs_kill),
    .fetch_hold    (fetch_hold),
    .redir_cnt     (redir_cnt),
    .sleep_cnt     (sleep_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  fl;       // {excp, ertn, refetch, idle, br, has_int, ready}
    logic [31:0] wbpc;     // drives excp_pc, era_pc and ws_pc
    logic [31:0] brpc;
    logic        kill;
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  cause;
    logic        hold;
    int          redir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [6:0] fl, input logic [31:0] wbpc, input logic [31:0] brpc,
                              input logic kill, input logic valid, input logic [31:0] pc,
                              input logic [2:0] cause, input logic hold, input int redir);
    vec_t t;
    t.fl = fl; t.wbpc = wbpc; t.brpc = brpc; t.kill = kill; t.valid = valid;
    t.pc = pc; t.cause = cause; t.hold = hold; t.redir = redir;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic [6:0] fl, input logic [31:0] wbpc, input logic [31:0] brpc);
    {excp_flush, ertn_flush, refetch_flush, idle_flush, br_flush, has_int, req_if.req_ready} = fl;
    excp_pc = wbpc; era_pc = wbpc; ws_pc = wbpc; br_target = brpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One vector: drive for a cycle, check the combinational kill, then the registered outputs.
  task automatic applyStimulus(input vec_t t, input int idx);
    drive(t.fl, t.wbpc, t.brpc);
    #1;
    checkOutput($sformatf("v%0d fs_kill", idx), {31'd0, fs_kill}, {31'd0, t.kill});
    step();
    checkOutput($sformatf("v%0d req_valid", idx), {31'd0, req_if.req_valid}, {31'd0, t.valid});
    checkOutput($sformatf("v%0d fetch_hold", idx), {31'd0, fetch_hold}, {31'd0, t.hold});
    checkOutput($sformatf("v%0d redir_cnt", idx), redir_cnt, t.redir);
    if (t.valid) begin
      checkOutput($sformatf("v%0d req_pc", idx), req_if.req_pc, t.pc);
      checkOutput($sformatf("v%0d req_cause", idx), {29'd0, req_if.req_cause}, {29'd0, t.cause});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    resetn = 1'b0;
    drive(7'b0, 32'h0, 32'h0);

    // Boot, then branch/flush scenarios starting from the boot request.
    vecs.push_back(mk(7'b0000000, 0, 0, 0, 1, RESET_PC, 0, 1, 0));
    vecs.push_back(mk(7'b0000000, 0, 0, 0, 1, RESET_PC, 0, 1, 0));
    vecs.push_back(mk(7'b0000000, 0, 0, 0, 1, RESET_PC, 0, 1, 0));
    vecs.push_back(mk(7'b0000001, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(7'b1000100, 32'h1c008000, 32'h1c000400, 1, 1, 32'h1c008000, 1, 1, 1));
    vecs.push_back(mk(7'b0000001, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(7'b0000100, 0, 32'h1c000100, 1, 1, 32'h1c000100, 5, 1, 2));
    vecs.push_back(mk(7'b0000000, 0, 0, 0, 1, 32'h1c000100, 5, 1, 2));
    vecs.push_back(mk(7'b0010000, 32'h1c000050, 0, 1, 1, 32'h1c000054, 3, 1, 2));
    vecs.push_back(mk(7'b0000100, 0, 32'h1c000300, 0, 1, 32'h1c000054, 3, 1, 2));
    vecs.push_back(mk(7'b0000001, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(7'b0000100, 0, 32'h1c000500, 1, 1, 32'h1c000500, 5, 1, 3));
    vecs.push_back(mk(7'b0100001, 32'h1c000200, 0, 1, 1, 32'h1c000200, 2, 1, 4));
    vecs.push_back(mk(7'b0000001, 0, 0, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(7'b0010000, 32'hfffffffc, 0, 1, 1, 32'h00000000, 3, 1, 5));
    vecs.push_back(mk(7'b0000001, 0, 0, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(7'b0001010, 32'h1c000400, 0, 1, 1, 32'h1c000404, 4, 1, 6));
    vecs.push_back(mk(7'b0000001, 0, 0, 0, 0, 0, 0, 0, 7));
    vecs.push_back(mk(7'b0000100, 0, 32'h1c000600, 1, 1, 32'h1c000600, 5, 1, 7));
    vecs.push_back(mk(7'b0000100, 0, 32'h1c000700, 1, 1, 32'h1c000700, 5, 1, 7));
    vecs.push_back(mk(7'b0000001, 0, 0, 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk(7'b0000100, 0, 32'h1c000800, 1, 1, 32'h1c000800, 5, 1, 8));
    vecs.push_back(mk(7'b0000101, 0, 32'h1c000900, 1, 1, 32'h1c000900, 5, 1, 9));
    vecs.push_back(mk(7'b0000001, 0, 0, 0, 0, 0, 0, 0, 10));

    #12;
    checkOutput("reset req_valid", {31'd0, req_if.req_valid}, 32'd1);
    checkOutput("reset req_pc", req_if.req_pc, RESET_PC);
    checkOutput("reset req_cause", {29'd0, req_if.req_cause}, 32'd0);
    checkOutput("reset fetch_hold", {31'd0, fetch_hold}, 32'd1);
    checkOutput("reset fs_kill", {31'd0, fs_kill}, 32'd0);
    checkOutput("reset redir_cnt", redir_cnt, 32'd0);
    checkOutput("reset sleep_cnt", sleep_cnt, 32'd0);
    resetn = 1'b1;
    step();

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Idle for ten sleeping cycles (a refetch in between is ignored), then interrupt wake.
    drive(7'b0001000, 32'h1c0000fc, 0);
    #1;
    checkOutput("idle fs_kill", {31'd0, fs_kill}, 32'd1);
    step();
    for (int i = 0; i < 10; i++) begin
      drive((i == 4) ? 7'b0010000 : 7'b0000000, 32'h1c000700, 0);
      checkOutput($sformatf("sleep%0d req_valid", i), {31'd0, req_if.req_valid}, 32'd0);
      checkOutput($sformatf("sleep%0d fetch_hold", i), {31'd0, fetch_hold}, 32'd1);
      step();
    end
    checkOutput("sleep_cnt after 10", sleep_cnt, 32'd10);
    checkOutput("still asleep", {31'd0, req_if.req_valid}, 32'd0);
    drive(7'b0000010, 0, 0);
    step();
    checkOutput("wake req_valid", {31'd0, req_if.req_valid}, 32'd1);
    checkOutput("wake req_pc", req_if.req_pc, 32'h1c000100);
    checkOutput("wake req_cause", {29'd0, req_if.req_cause}, 32'd4);
    checkOutput("wake sleep_cnt", sleep_cnt, 32'd11);
    drive(7'b0000001, 0, 0);
    step();
    checkOutput("wake accepted redir_cnt", redir_cnt, 32'd11);

    // Exception taken while asleep leaves SLEEP with the exception target.
    drive(7'b0001000, 32'h1c001000, 0);
    step();
    drive(7'b0000000, 0, 0);
    step();
    drive(7'b1000100, 32'h1c00a000, 32'h1c000b00);
    #1;
    checkOutput("sleep excp fs_kill", {31'd0, fs_kill}, 32'd1);
    step();
    checkOutput("sleep excp req_valid", {31'd0, req_if.req_valid}, 32'd1);
    checkOutput("sleep excp req_pc", req_if.req_pc, 32'h1c00a000);
    checkOutput("sleep excp req_cause", {29'd0, req_if.req_cause}, 32'd1);
    checkOutput("sleep excp sleep_cnt", sleep_cnt, 32'd13);
    drive(7'b0000001, 0, 0);
    step();
    checkOutput("sleep excp redir_cnt", redir_cnt, 32'd12);

    // Reset pulsed mid-PEND abandons the branch request and reissues the boot fetch.
    drive(7'b0000100, 0, 32'h1c000c00);
    step();
    drive(7'b0000000, 0, 0);
    checkOutput("pre-reset req_pc", req_if.req_pc, 32'h1c000c00);
    #3 resetn = 1'b0;
    #1;
    checkOutput("midreset req_valid", {31'd0, req_if.req_valid}, 32'd1);
    checkOutput("midreset req_pc", req_if.req_pc, RESET_PC);
    checkOutput("midreset req_cause", {29'd0, req_if.req_cause}, 32'd0);
    checkOutput("midreset redir_cnt", redir_cnt, 32'd0);
    checkOutput("midreset sleep_cnt", sleep_cnt, 32'd0);
    @(posedge clk);
    #3 resetn = 1'b1;
    step();
    checkOutput("reboot req_pc", req_if.req_pc, RESET_PC);
    drive(7'b0000001, 0, 0);
    step();
    checkOutput("reboot accepted", {31'd0, req_if.req_valid}, 32'd0);
    checkOutput("reboot redir_cnt", redir_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
